fpu_issue_arbiter: RTL and testbench
====================================

Name: fpu_issue_arbiter

Overview:
- Shares the single half-precision FPU execution unit between NUM_REQ requesters, for example the core decode pipe and a debug/test-access port.
- Arbitrates round-robin and issues one operation at a time to the execution unit.
- Waits for the unit's completion, then holds the result in a response register until the owning requester accepts it.
- Rejects opcodes the unit does not complete, and recovers from a missing completion with a watchdog.

Parameters:
FPLEN, 16, floating-point operand/result width
NUM_REQ, 2, number of requesters (2..4)
TAG_W, 4, requester-supplied tag width, echoed in the response
TIMEOUT, 8, cycles to wait for exu_complete before an error response (>=2)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester grant; a request is taken when valid&ready
req_op  in  NUM_REQ*24  one-hot sfpu_op encoding per requester
req_rnd  in  NUM_REQ*3  rounding mode
req_ctrl  in  NUM_REQ*4  float_control per requester
req_rs1_en  in  NUM_REQ  rs1 comes from GPR
req_gpr_rs1  in  NUM_REQ*32  integer operand
req_fs1, req_fs2, req_fs3  in  NUM_REQ*FPLEN  float operands
req_tag  in  NUM_REQ*TAG_W  request tag
exu_valid  out  1  one-cycle issue strobe (valid_execution); fpu_sel[0] driven equal to it
exu_sfpu_op  out  24  issued opcode; zero when not issuing
exu_rnd, exu_ctrl, exu_rs1_en, exu_gpr_rs1, exu_fs1..3  out  per field  issued operands; zero when not issuing
exu_complete  in  1  execution-unit completion
exu_complete_rd  in  1  completion targets integer rd
exu_result_1  in  FPLEN  float result
exu_result_rd  in  32  integer result
exu_flags  in  5  accrued flags (NV,DZ,OF,UF,NX)
rsp_valid  out  NUM_REQ  response valid, one-hot to the owner
rsp_ready  in  NUM_REQ  response accept
rsp_fp  out  FPLEN  float result
rsp_rd  out  32  integer result
rsp_is_rd  out  1  result is in rsp_rd
rsp_flags  out  5  flags
rsp_err  out  1  rejected op or timeout
rsp_tag  out  TAG_W  echoed tag

Behaviour:
- Reset (any cycle, including mid-operation): state is IDLE; all outputs are 0; the round-robin pointer is 0; the watchdog is 0. Any outstanding operation is dropped with no response. A late exu_complete arriving in IDLE is ignored.
- States:
  - IDLE:
    - Grant the first valid requester at or after the pointer. req_ready is asserted combinationally for that requester only, and only in IDLE.
    - On handshake, latch tag and owner; the pointer becomes owner+1 mod NUM_REQ.
    - If the op is legal, go to ISSUE. Legal means exactly one bit set in op[2:0], op[21:5], with op[22]/op[23] allowed as modifiers.
    - Otherwise (op[3] fdiv, op[4] fsqrt, zero bits, or multiple bits set) go to RESP with rsp_err=1, flags=5'b10000 (NV), and no issue.
  - ISSUE (1 cycle): drive exu_valid=1 with the latched fields; go to WAIT and clear the watchdog.
  - WAIT:
    - Capture exu_complete on the first cycle it is seen. This is nominally the cycle after ISSUE.
    - On capture: rsp_fp <= exu_result_1, rsp_rd <= exu_result_rd, rsp_is_rd <= exu_complete_rd, rsp_flags <= exu_flags, rsp_err <= 0; go to RESP.
    - The watchdog increments each WAIT cycle. When it reaches TIMEOUT without completion, go to RESP with rsp_err=1, flags=0, results=0.
  - RESP:
    - rsp_valid[owner]=1; all rsp_* fields stay stable until rsp_ready[owner].
    - On accept, go to IDLE. A new grant is possible no earlier than the next cycle.
- Issue-to-response latency with an immediate complete: handshake cycle N, exu_valid at N+1, complete at N+2, rsp_valid at N+3.
- Operands and opcodes are never forwarded while exu_valid=0. The execution unit only ever sees zero operands between issues.
- Simultaneous req_valid from several requesters: only one grant per IDLE cycle. The others wait, with their inputs required to stay stable while valid.
- A requester dropping req_valid before it is granted is legal and produces no effect.

Decomposition:
- Shared package fpu_pkg:
  - sfpu_op bit-index constants (FADD=0 … SIGN=23);
  - state encoding (IDLE, ISSUE, WAIT, RESP);
  - flag bit positions;
  - an ILLEGAL_OP_MASK with bits 3 and 4 set.
- One sub-module, fpu_rr_arbiter: a parameterised round-robin grant with a pointer update on accept. Everything else stays in the top module.

Test Plan:
- Req0 sends fadd (op bit0), fs1=0x3C00, fs2=0x3C00, tag=3; stub completes next cycle with 0x4000, flags 0 -> exu_valid exactly one cycle; rsp_valid[0] 3 cycles after the handshake; rsp_fp=0x4000, rsp_tag=3, rsp_err=0.
- Both requesters valid continuously from reset, rsp_ready=1 -> grants alternate 0,1,0,1; each response goes only to its owner.
- Req1 sends fdiv (bit3) -> no exu_valid; rsp_err=1, rsp_flags=5'b10000; the pointer still advances.
- feq (bit9); stub returns exu_complete_rd=1, result_rd=1 -> rsp_is_rd=1, rsp_rd=32'h1.
- Stub never completes, TIMEOUT=8 -> rsp_err=1 after 8 WAIT cycles; a late exu_complete after returning to IDLE is ignored.
- rsp_ready held low for 5 cycles -> rsp fields stable and req_ready=0 throughout; assert rst in WAIT -> all outputs 0 next cycle and no response.

Source files
------------

// File: rtl/fpu_pkg.sv
// fpu_pkg: shared opcode bit indices, FSM encoding, flag positions and legality check for the FPU issue path.
package fpu_pkg;
  localparam int FADD = 0, FSUB = 1, FMUL = 2, FDIV = 3, FSQRT = 4, FMADD = 5;
  localparam int FMSUB = 6, FNMSUB = 7, FNMADD = 8, FEQ = 9, FLT = 10, FLE = 11;
  localparam int FMIN = 12, FMAX = 13, FCLASS = 14, FCVT_W_S = 15, FCVT_WU_S = 16;
  localparam int FCVT_S_W = 17, FCVT_S_WU = 18, FMV_X_W = 19, FMV_W_X = 20;
  localparam int FSGNJ = 21, NEG = 22, SIGN = 23;
  localparam int OP_W = 24;
  localparam logic [1:0] S_IDLE = 2'd0, S_ISSUE = 2'd1, S_WAIT = 2'd2, S_RESP = 2'd3;
  localparam int FLAG_NX = 0, FLAG_UF = 1, FLAG_OF = 2, FLAG_DZ = 3, FLAG_NV = 4;
  localparam logic [4:0] FLAGS_NV = 5'b10000;
  localparam logic [OP_W-1:0] ILLEGAL_OP_MASK = 24'h000018;
  // bits 22/23 are modifiers and do not count toward the one-hot check
  function automatic logic op_legal(input logic [OP_W-1:0] op);
    logic [21:0] m;
    m = op[21:0];
    return (m != '0) && ((m & (m - 22'd1)) == '0) && ((m & ILLEGAL_OP_MASK[21:0]) == '0);
  endfunction
endpackage

// File: rtl/fpu_rr_arbiter.sv
// fpu_rr_arbiter: round-robin one-hot grant starting at a pointer that moves past the owner on accept.
module fpu_rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          accept,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] gidx
);
  logic [PW-1:0] ptr;
  // scan from farthest to nearest so the requester closest to ptr wins
  always_comb begin
    grant = '0;
    gidx  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[(int'(ptr) + i) % N]) begin
        gidx = PW'((int'(ptr) + i) % N);
        grant = '0;
        grant[(int'(ptr) + i) % N] = 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) ptr <= '0;
    else if (accept) ptr <= (gidx == PW'(N - 1)) ? '0 : gidx + PW'(1);
  end
endmodule

// File: rtl/fpu_issue_arbiter.sv
// fpu_issue_arbiter: shares one FPU execution unit between requesters, one operation in flight,
// with illegal-op rejection and a completion watchdog.
module fpu_issue_arbiter
  import fpu_pkg::*;
#(
  parameter int FPLEN   = 16,
  parameter int NUM_REQ = 2,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*24-1:0]    req_op,
  input  logic [NUM_REQ*3-1:0]     req_rnd,
  input  logic [NUM_REQ*4-1:0]     req_ctrl,
  input  logic [NUM_REQ-1:0]       req_rs1_en,
  input  logic [NUM_REQ*32-1:0]    req_gpr_rs1,
  input  logic [NUM_REQ*FPLEN-1:0] req_fs1,
  input  logic [NUM_REQ*FPLEN-1:0] req_fs2,
  input  logic [NUM_REQ*FPLEN-1:0] req_fs3,
  input  logic [NUM_REQ*TAG_W-1:0] req_tag,
  output logic                     exu_valid,
  output logic [23:0]              exu_sfpu_op,
  output logic [2:0]               exu_rnd,
  output logic [3:0]               exu_ctrl,
  output logic                     exu_rs1_en,
  output logic [31:0]              exu_gpr_rs1,
  output logic [FPLEN-1:0]         exu_fs1,
  output logic [FPLEN-1:0]         exu_fs2,
  output logic [FPLEN-1:0]         exu_fs3,
  input  logic                     exu_complete,
  input  logic                     exu_complete_rd,
  input  logic [FPLEN-1:0]         exu_result_1,
  input  logic [31:0]              exu_result_rd,
  input  logic [4:0]               exu_flags,
  output logic [NUM_REQ-1:0]       rsp_valid,
  input  logic [NUM_REQ-1:0]       rsp_ready,
  output logic [FPLEN-1:0]         rsp_fp,
  output logic [31:0]              rsp_rd,
  output logic                     rsp_is_rd,
  output logic [4:0]               rsp_flags,
  output logic                     rsp_err,
  output logic [TAG_W-1:0]         rsp_tag
);
  localparam int OW = $clog2(NUM_REQ);
  localparam int WW = $clog2(TIMEOUT + 1);
  logic [1:0]         state;
  logic [OW-1:0]      owner, gidx;
  logic [WW-1:0]      wd;
  logic [NUM_REQ-1:0] arb_req, grant;
  logic               take, issue;
  logic [23:0]        op_q, op_sel;
  logic [2:0]         rnd_q;
  logic [3:0]         ctrl_q;
  logic               rs1_en_q;
  logic [31:0]        gpr_q;
  logic [FPLEN-1:0]   fs1_q, fs2_q, fs3_q;
  assign arb_req   = (state == S_IDLE && !rst) ? req_valid : '0;
  assign req_ready = grant;
  assign take      = |grant;
  assign op_sel    = req_op[int'(gidx)*24 +: 24];
  assign issue     = state == S_ISSUE;
  fpu_rr_arbiter #(.N(NUM_REQ), .PW(OW)) u_arb (
    .clk   (clk),
    .rst   (rst),
    .req   (arb_req),
    .accept(take),
    .grant (grant),
    .gidx  (gidx)
  );
  // the unit sees zeros on every operand lane outside the issue cycle
  assign exu_valid   = issue;
  assign exu_sfpu_op = issue ? op_q : '0;
  assign exu_rnd     = issue ? rnd_q : '0;
  assign exu_ctrl    = issue ? ctrl_q : '0;
  assign exu_rs1_en  = issue & rs1_en_q;
  assign exu_gpr_rs1 = issue ? gpr_q : '0;
  assign exu_fs1     = issue ? fs1_q : '0;
  assign exu_fs2     = issue ? fs2_q : '0;
  assign exu_fs3     = issue ? fs3_q : '0;
  assign rsp_valid   = (state == S_RESP) ? (NUM_REQ'(1) << owner) : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      owner     <= '0;
      wd        <= '0;
      op_q      <= '0;
      rnd_q     <= '0;
      ctrl_q    <= '0;
      rs1_en_q  <= 1'b0;
      gpr_q     <= '0;
      fs1_q     <= '0;
      fs2_q     <= '0;
      fs3_q     <= '0;
      rsp_fp    <= '0;
      rsp_rd    <= '0;
      rsp_is_rd <= 1'b0;
      rsp_flags <= '0;
      rsp_err   <= 1'b0;
      rsp_tag   <= '0;
    end else begin
      case (state)
        S_IDLE: if (take) begin
          owner    <= gidx;
          rsp_tag  <= req_tag[int'(gidx)*TAG_W +: TAG_W];
          op_q     <= op_sel;
          rnd_q    <= req_rnd[int'(gidx)*3 +: 3];
          ctrl_q   <= req_ctrl[int'(gidx)*4 +: 4];
          rs1_en_q <= req_rs1_en[gidx];
          gpr_q    <= req_gpr_rs1[int'(gidx)*32 +: 32];
          fs1_q    <= req_fs1[int'(gidx)*FPLEN +: FPLEN];
          fs2_q    <= req_fs2[int'(gidx)*FPLEN +: FPLEN];
          fs3_q    <= req_fs3[int'(gidx)*FPLEN +: FPLEN];
          if (op_legal(op_sel)) state <= S_ISSUE;
          else begin
            state     <= S_RESP;
            rsp_fp    <= '0;
            rsp_rd    <= '0;
            rsp_is_rd <= 1'b0;
            rsp_flags <= FLAGS_NV;
            rsp_err   <= 1'b1;
          end
        end
        S_ISSUE: begin
          state <= S_WAIT;
          wd    <= '0;
        end
        S_WAIT: if (exu_complete) begin
          state     <= S_RESP;
          rsp_fp    <= exu_result_1;
          rsp_rd    <= exu_result_rd;
          rsp_is_rd <= exu_complete_rd;
          rsp_flags <= exu_flags;
          rsp_err   <= 1'b0;
        end else if (wd == WW'(TIMEOUT - 1)) begin
          state     <= S_RESP;
          rsp_fp    <= '0;
          rsp_rd    <= '0;
          rsp_is_rd <= 1'b0;
          rsp_flags <= '0;
          rsp_err   <= 1'b1;
        end else wd <= wd + WW'(1);
        S_RESP: if (rsp_ready[owner]) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fpu_issue_arbiter.sv
// tb_fpu_issue_arbiter: directed scenarios against a hand-driven execution-unit stub.
module tb_fpu_issue_arbiter;
  logic        clk = 0, rst = 0;
  logic [1:0]  req_valid = 0, req_ready, req_rs1_en = 0, rsp_valid, rsp_ready = 0;
  logic [47:0] req_op = 0;
  logic [5:0]  req_rnd = 0;
  logic [7:0]  req_ctrl = 0, req_tag = 0;
  logic [63:0] req_gpr_rs1 = 0;
  logic [31:0] req_fs1 = 0, req_fs2 = 0, req_fs3 = 0;
  logic        exu_valid, exu_rs1_en, exu_complete = 0, exu_complete_rd = 0, rsp_is_rd, rsp_err;
  logic [23:0] exu_sfpu_op;
  logic [2:0]  exu_rnd;
  logic [3:0]  exu_ctrl, rsp_tag;
  logic [31:0] exu_gpr_rs1, exu_result_rd = 0, rsp_rd;
  logic [15:0] exu_fs1, exu_fs2, exu_fs3, exu_result_1 = 0, rsp_fp;
  logic [4:0]  exu_flags = 0, rsp_flags;
  int total = 0, bad = 0;

  fpu_issue_arbiter #(.FPLEN(16), .NUM_REQ(2), .TAG_W(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_rnd(req_rnd), .req_ctrl(req_ctrl), .req_rs1_en(req_rs1_en), .req_gpr_rs1(req_gpr_rs1),
    .req_fs1(req_fs1), .req_fs2(req_fs2), .req_fs3(req_fs3), .req_tag(req_tag),
    .exu_valid(exu_valid), .exu_sfpu_op(exu_sfpu_op), .exu_rnd(exu_rnd), .exu_ctrl(exu_ctrl),
    .exu_rs1_en(exu_rs1_en), .exu_gpr_rs1(exu_gpr_rs1), .exu_fs1(exu_fs1), .exu_fs2(exu_fs2),
    .exu_fs3(exu_fs3), .exu_complete(exu_complete), .exu_complete_rd(exu_complete_rd),
    .exu_result_1(exu_result_1), .exu_result_rd(exu_result_rd), .exu_flags(exu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_fp(rsp_fp), .rsp_rd(rsp_rd),
    .rsp_is_rd(rsp_is_rd), .rsp_flags(rsp_flags), .rsp_err(rsp_err), .rsp_tag(rsp_tag)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1;
    tick;
    tick;
    rst = 0;
    #1;
  endtask

  task automatic set_req(input int i, input logic [23:0] op, input logic [15:0] a, input logic [15:0] b, input logic [3:0] tag);
    req_op[i*24 +: 24] = op;
    req_fs1[i*16 +: 16] = a;
    req_fs2[i*16 +: 16] = b;
    req_tag[i*4 +: 4] = tag;
  endtask

  task automatic test_reset;
    req_valid = 2'b11;
    set_req(0, 24'h1, 16'h3C00, 16'h3C00, 4'd1);
    rst = 1;
    tick;
    tick;
    total++;
    if ({req_ready, exu_valid, exu_sfpu_op, exu_fs1, rsp_valid, rsp_fp, rsp_rd, rsp_is_rd, rsp_flags, rsp_err, rsp_tag} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: req_ready=%b exu_valid=%b rsp_valid=%b rsp_tag=%h want all zero", req_ready, exu_valid, rsp_valid, rsp_tag);
    end
    req_valid = 0;
    rst = 0;
    #1;
  endtask

  task automatic test_fadd;
    set_req(0, 24'h1, 16'h3C00, 16'h3C00, 4'd3);
    req_valid = 2'b01;
    #1;
    total++;
    if (req_ready !== 2'b01) begin bad++; $display("FAIL fadd_ready: got %b want 01", req_ready); end
    tick;
    req_valid = 0;
    total++;
    if ({exu_valid, exu_sfpu_op, exu_fs1, exu_fs2} !== {1'b1, 24'h1, 16'h3C00, 16'h3C00}) begin
      bad++; $display("FAIL fadd_issue: valid=%b op=%h fs1=%h fs2=%h want 1 000001 3c00 3c00", exu_valid, exu_sfpu_op, exu_fs1, exu_fs2);
    end
    tick;
    total++;
    if ({exu_valid, exu_sfpu_op, exu_fs1, rsp_valid} !== '0) begin
      bad++; $display("FAIL fadd_one_cycle: valid=%b op=%h fs1=%h rsp_valid=%b want zeros", exu_valid, exu_sfpu_op, exu_fs1, rsp_valid);
    end
    exu_complete = 1;
    exu_result_1 = 16'h4000;
    exu_flags = 0;
    tick;
    exu_complete = 0;
    total++;
    if ({rsp_valid, rsp_fp, rsp_tag, rsp_err, rsp_is_rd} !== {2'b01, 16'h4000, 4'd3, 1'b0, 1'b0}) begin
      bad++; $display("FAIL fadd_rsp: valid=%b fp=%h tag=%h err=%b is_rd=%b want 01 4000 3 0 0", rsp_valid, rsp_fp, rsp_tag, rsp_err, rsp_is_rd);
    end
    rsp_ready = 2'b01;
    tick;
    rsp_ready = 0;
    total++;
    if (rsp_valid !== 2'b00) begin bad++; $display("FAIL fadd_accept: rsp_valid=%b want 00", rsp_valid); end
  endtask

  task automatic test_alternate;
    logic [1:0] exp;
    int n;
    set_req(0, 24'h1, 16'h1111, 16'h2222, 4'd5);
    set_req(1, 24'h4, 16'h3333, 16'h4444, 4'd6);
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    exu_complete = 1;
    exu_result_1 = 16'h1234;
    do_reset;
    for (int k = 0; k < 4; k++) begin
      exp = (k % 2 == 1) ? 2'b10 : 2'b01;
      n = 0;
      while (req_ready == 0 && n < 10) begin tick; n++; end
      total++;
      if (req_ready !== exp) begin bad++; $display("FAIL alt_grant%0d: got %b want %b", k, req_ready, exp); end
      tick;
      n = 0;
      while (rsp_valid == 0 && n < 10) begin tick; n++; end
      total++;
      if ({rsp_valid, rsp_tag} !== {exp, (k % 2 == 1) ? 4'd6 : 4'd5}) begin
        bad++; $display("FAIL alt_rsp%0d: valid=%b tag=%h want %b %0d", k, rsp_valid, rsp_tag, exp, (k % 2 == 1) ? 6 : 5);
      end
      tick;
    end
    req_valid = 0;
    rsp_ready = 0;
    exu_complete = 0;
    #1;
  endtask

  task automatic test_illegal;
    set_req(0, 24'h3, 16'h0, 16'h0, 4'd7);
    req_valid = 2'b01;
    tick;
    req_valid = 0;
    total++;
    if ({exu_valid, rsp_valid, rsp_err, rsp_flags, rsp_tag} !== {1'b0, 2'b01, 1'b1, 5'b10000, 4'd7}) begin
      bad++; $display("FAIL multibit_rsp: exu_valid=%b rsp_valid=%b err=%b flags=%b tag=%h", exu_valid, rsp_valid, rsp_err, rsp_flags, rsp_tag);
    end
    rsp_ready = 2'b01;
    tick;
    rsp_ready = 0;
    set_req(1, 24'h8, 16'h3C00, 16'h4000, 4'd9);
    req_valid = 2'b10;
    #1;
    total++;
    if (req_ready !== 2'b10) begin bad++; $display("FAIL fdiv_ready: got %b want 10", req_ready); end
    tick;
    req_valid = 0;
    total++;
    if ({exu_valid, exu_sfpu_op, rsp_valid, rsp_err, rsp_flags, rsp_fp} !== {1'b0, 24'h0, 2'b10, 1'b1, 5'b10000, 16'h0}) begin
      bad++; $display("FAIL fdiv_rsp: exu_valid=%b op=%h rsp_valid=%b err=%b flags=%b fp=%h", exu_valid, exu_sfpu_op, rsp_valid, rsp_err, rsp_flags, rsp_fp);
    end
    rsp_ready = 2'b10;
    tick;
    rsp_ready = 0;
    set_req(0, 24'h1, 16'h0, 16'h0, 4'd1);
    set_req(1, 24'h1, 16'h0, 16'h0, 4'd2);
    req_valid = 2'b11;
    #1;
    total++;
    if (req_ready !== 2'b01) begin bad++; $display("FAIL fdiv_ptr: got %b want 01", req_ready); end
    req_valid = 0;
    #1;
  endtask

  task automatic test_feq;
    set_req(0, 24'h200, 16'h3C00, 16'h3C00, 4'd4);
    req_valid = 2'b01;
    tick;
    req_valid = 0;
    total++;
    if ({exu_valid, exu_sfpu_op} !== {1'b1, 24'h200}) begin bad++; $display("FAIL feq_issue: valid=%b op=%h want 1 000200", exu_valid, exu_sfpu_op); end
    tick;
    exu_complete = 1;
    exu_complete_rd = 1;
    exu_result_rd = 32'h1;
    exu_result_1 = 16'h0;
    tick;
    exu_complete = 0;
    exu_complete_rd = 0;
    exu_result_rd = 0;
    total++;
    if ({rsp_valid, rsp_is_rd, rsp_rd, rsp_err, rsp_tag} !== {2'b01, 1'b1, 32'h1, 1'b0, 4'd4}) begin
      bad++; $display("FAIL feq_rsp: valid=%b is_rd=%b rd=%h err=%b tag=%h", rsp_valid, rsp_is_rd, rsp_rd, rsp_err, rsp_tag);
    end
    rsp_ready = 2'b01;
    tick;
    rsp_ready = 0;
  endtask

  task automatic test_timeout;
    set_req(0, 24'h1, 16'h3C00, 16'h3C00, 4'd8);
    req_valid = 2'b01;
    tick;
    req_valid = 0;
    tick;
    for (int i = 0; i < 7; i++) tick;
    total++;
    if (rsp_valid !== 2'b00) begin bad++; $display("FAIL timeout_early: rsp_valid=%b want 00 after 7 wait cycles", rsp_valid); end
    tick;
    total++;
    if ({rsp_valid, rsp_err, rsp_flags, rsp_fp, rsp_rd, rsp_tag} !== {2'b01, 1'b1, 5'b0, 16'h0, 32'h0, 4'd8}) begin
      bad++; $display("FAIL timeout_rsp: valid=%b err=%b flags=%b fp=%h rd=%h tag=%h", rsp_valid, rsp_err, rsp_flags, rsp_fp, rsp_rd, rsp_tag);
    end
    rsp_ready = 2'b01;
    tick;
    rsp_ready = 0;
    exu_complete = 1;
    exu_result_1 = 16'h7777;
    tick;
    tick;
    exu_complete = 0;
    total++;
    if ({rsp_valid, exu_valid, rsp_fp} !== {2'b00, 1'b0, 16'h0}) begin
      bad++; $display("FAIL late_complete: rsp_valid=%b exu_valid=%b fp=%h want 00 0 0000", rsp_valid, exu_valid, rsp_fp);
    end
  endtask

  task automatic test_hold;
    set_req(0, 24'h2, 16'h4000, 16'h4000, 4'hA);
    set_req(1, 24'h1, 16'h0, 16'h0, 4'hB);
    req_valid = 2'b01;
    tick;
    req_valid = 0;
    tick;
    exu_complete = 1;
    exu_result_1 = 16'h4400;
    exu_flags = 5'b00001;
    tick;
    exu_complete = 0;
    exu_result_1 = 0;
    exu_flags = 0;
    req_valid = 2'b10;
    #1;
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({rsp_valid, rsp_fp, rsp_flags, rsp_tag, req_ready} !== {2'b01, 16'h4400, 5'b00001, 4'hA, 2'b00}) begin
        bad++; $display("FAIL hold%0d: valid=%b fp=%h flags=%b tag=%h req_ready=%b", i, rsp_valid, rsp_fp, rsp_flags, rsp_tag, req_ready);
      end
      tick;
    end
    rsp_ready = 2'b01;
    tick;
    rsp_ready = 0;
    total++;
    if ({rsp_valid, req_ready} !== {2'b00, 2'b10}) begin
      bad++; $display("FAIL hold_release: rsp_valid=%b req_ready=%b want 00 10", rsp_valid, req_ready);
    end
    req_valid = 0;
    #1;
  endtask

  task automatic test_reset_mid;
    set_req(0, 24'h1, 16'h3C00, 16'h3C00, 4'd2);
    req_valid = 2'b01;
    tick;
    req_valid = 0;
    tick;
    rst = 1;
    tick;
    total++;
    if ({req_ready, exu_valid, exu_sfpu_op, exu_fs1, rsp_valid, rsp_fp, rsp_rd, rsp_is_rd, rsp_flags, rsp_err, rsp_tag} !== '0) begin
      bad++; $display("FAIL reset_mid: exu_valid=%b rsp_valid=%b tag=%h want all zero", exu_valid, rsp_valid, rsp_tag);
    end
    rst = 0;
    exu_complete = 1;
    exu_result_1 = 16'h5555;
    tick;
    tick;
    exu_complete = 0;
    total++;
    if ({rsp_valid, exu_valid, rsp_fp} !== {2'b00, 1'b0, 16'h0}) begin
      bad++; $display("FAIL reset_no_rsp: rsp_valid=%b exu_valid=%b fp=%h want 00 0 0000", rsp_valid, exu_valid, rsp_fp);
    end
  endtask

  initial begin
    test_reset;
    test_fadd;
    test_alternate;
    test_illegal;
    test_feq;
    test_timeout;
    test_hold;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
